seq_pattern_tx: RTL and testbench
=================================

// Module: seq_pattern_tx
// PURPOSE
//   Serial pattern transmitter: drives the 1-bit serial stream that the sequence
//   recognizers consume. Captures a parallel word on start, then shifts its low
//   len bits out MSB-first, one bit per clk. The burst repeats rep times, with
//   GAP idle cycles between repeats. Serves as the stimulus source for
//   sequence-detector blocks, and is also a standalone serializer.
// PARAMETERS
//   WIDTH  16   max pattern length in bits (>=2)
//   CNT_W  5    width of len / bit counter, = $clog2(WIDTH+1)
//   REP_W  4    width of repeat count
//   GAP    0    idle cycles (out=0, valid=0) inserted between repeats
// PORTS
//   clk    in   1      rising-edge clock
//   reset  in   1      async, active-low; 0 clears all state immediately
//   start  in   1      request; sampled only in IDLE
//   data   in   WIDTH  pattern; bit len-1 is sent first
//   len    in   CNT_W  bits per burst, 0..WIDTH; values >WIDTH clamp to WIDTH
//   rep    in   REP_W  bursts to send; 0 is treated as 1
//   out    out  1      serial bit; forced 0 whenever valid=0
//   valid  out  1      out carries a pattern bit this cycle
//   busy   out  1      transfer in progress; start is ignored while 1
//   done   out  1      one-cycle pulse after the final bit
// BEHAVIOUR
//   - One clock domain; single always block on posedge clk or negedge reset.
//   - Reset (reset=0, async): state=IDLE. out=0, valid=0, busy=0, done=0.
//     Shift reg and counters clear to 0.
//   - All outputs are registered. No combinational path from inputs to outputs.
//   - States: IDLE, SEND, GAP, DONE.
//   - IDLE:  busy=0. On start=1 at edge k: latch data, len (clamped), rep (0->1).
//            len!=0 -> SEND. len==0 -> DONE.
//   - SEND:  valid=1, out=shreg[len-1]. First bit is visible in the cycle after
//            edge k. Shift left each cycle. bitcnt counts len..1.
//            After the last bit: if reps remain, go to GAP (GAP>0) or reload the
//            shreg and stay in SEND (GAP=0, back-to-back bits). Otherwise DONE.
//   - GAP:   valid=0, out=0 for exactly GAP cycles, then reload and go to SEND.
//   - DONE:  done=1, busy=1, valid=0 for one cycle, then IDLE. A start asserted
//            during DONE is ignored. A start in the first IDLE cycle is accepted.
//   - Latency: start edge -> first valid bit = 1 cycle.
//     Total cycles start->done = rep*len + (rep-1)*GAP + 1.
//   - data, len and rep may change freely after capture. Only latched copies are used.
//   - start held high continuously gives back-to-back transfers, one IDLE
//     cycle between done and the next first bit.
//   - Reset mid-transfer aborts at once. No done pulse. After release: IDLE.
//   - Counter widths: bitcnt CNT_W, repcnt REP_W. No wrap; counters stop at 0.
// STRUCTURE
//   - Shared package seq_pkg: state encoding constants (IDLE=2'b00, SEND=2'b01,
//     GAP=2'b10, DONE=2'b11). The recognizers reference the same file.
//   - One sub-module: seq_piso (WIDTH-bit parallel-in/serial-out shift register
//     with load, shift and a tap-select of bit len-1).
//   - FSM, bit counter and repeat counter live in the top.
// TESTING
//   1 reset=0 at any time -> out=0, valid=0, busy=0, done=0 in the same cycle.
//   2 data=16'h0005, len=3, rep=1 -> out 1,0,1 with valid for 3 cycles.
//     done=1 in cycle 4. busy=1 cycles 1-4.
//   3 data=16'h0005, len=3, rep=3, GAP=0 -> out 101101101, 9 valid cycles.
//     A paired "101" recognizer fires at bits 3, 6 and 9.
//   4 len=0 -> no valid cycle, done pulse 1 cycle after start.
//     rep=0, len=2, data=2'b10 -> single burst "10".
//   5 data=16'hA5F0, len=16 -> MSB-first 1010010111110000.
//     Change data and pulse start mid-burst -> stream unchanged, request ignored.
//   6 reset=0 during bit 2 of case 2 -> outputs drop immediately, no done.
//     After release, start with case 2 stimulus -> correct "101" burst.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared encodings for the serial pattern transmitter and the
// sequence recognizers that consume its stream.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/seq_piso.sv
// Parallel-in/serial-out shift register. It keeps the captured
// pattern for reloads between repeats and a working copy that
// shifts left. Ports: capture (take din), reload (restore the
// pattern), shift (move left one bit), sel (tap index, len-1),
// tap_nxt (tapped bit of the next register value, so that the
// parent can register it in the same cycle the register updates).
module seq_piso
  import seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             reload,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] sel,
  output logic             tap_nxt
);

  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] sh_q, sh_d;

  always_comb begin
    pat_d = pat_q;
    sh_d  = sh_q;
    if (capture) begin
      pat_d = din;
      sh_d  = din;
    end else if (reload) begin
      sh_d = pat_q;
    end else if (shift) begin
      sh_d = {sh_q[WIDTH-2:0], 1'b0};
    end
  end

  // Mux loop keeps sel width independent of WIDTH.
  always_comb begin
    tap_nxt = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel == CNT_W'(i)) tap_nxt = sh_d[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q <= '0;
      sh_q  <= '0;
    end else begin
      pat_q <= pat_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captures data/len/rep on start and
// sends the low len bits MSB-first, rep times, GAP idle cycles
// between repeats. Ports: clk, reset (async, active-low), start,
// data, len, rep in; out, valid, busy, done out (all registered).
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5,
  parameter int REP_W = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [CNT_W-1:0] len,
  input  logic [REP_W-1:0] rep,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [REP_W-1:0] repcnt_q, repcnt_d;
  logic [CNT_W-1:0] lenl_q, lenl_d;
  logic [GW-1:0]    gapcnt_q, gapcnt_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] len_c;
  logic [REP_W-1:0] rep_c;
  logic [CNT_W-1:0] sel;
  logic             capture, reload, shift;
  logic             tap_nxt;

  seq_piso #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_piso (
    .clk     (clk),
    .reset   (reset),
    .capture (capture),
    .reload  (reload),
    .shift   (shift),
    .din     (data),
    .sel     (sel),
    .tap_nxt (tap_nxt)
  );

  always_comb begin
    len_c = (len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : len;
    rep_c = (rep == '0) ? REP_W'(1) : rep;
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    repcnt_d = repcnt_q;
    lenl_d   = lenl_q;
    gapcnt_d = gapcnt_q;
    capture  = 1'b0;
    reload   = 1'b0;
    shift    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          capture  = 1'b1;
          lenl_d   = len_c;
          repcnt_d = rep_c;
          bitcnt_d = len_c;
          state_d  = (len_c != '0) ? ST_SEND : ST_DONE;
        end
      end
      ST_SEND: begin
        if (bitcnt_q > CNT_W'(1)) begin
          shift    = 1'b1;
          bitcnt_d = bitcnt_q - CNT_W'(1);
        end else begin
          bitcnt_d = '0;
          if (repcnt_q > REP_W'(1)) begin
            repcnt_d = repcnt_q - REP_W'(1);
            if (GAP > 0) begin
              state_d  = ST_GAP;
              gapcnt_d = GW'(GAP);
            end else begin
              reload   = 1'b1;
              bitcnt_d = lenl_q;
            end
          end else begin
            repcnt_d = '0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_GAP: begin
        if (gapcnt_q > GW'(1)) begin
          gapcnt_d = gapcnt_q - GW'(1);
        end else begin
          gapcnt_d = '0;
          reload   = 1'b1;
          bitcnt_d = lenl_q;
          state_d  = ST_SEND;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the
  // first bit appears the cycle after the capturing edge.
  always_comb begin
    sel     = (lenl_d != '0) ? lenl_d - CNT_W'(1) : '0;
    valid_d = (state_d == ST_SEND);
    out_d   = valid_d & tap_nxt;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      repcnt_q <= '0;
      lenl_q   <= '0;
      gapcnt_q <= '0;
      out_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      repcnt_q <= repcnt_d;
      lenl_q   <= lenl_d;
      gapcnt_q <= gapcnt_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: expected serial bits are queued
// at start and checked by a monitor as valid bits come out.
module tb_seq_pattern_tx;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] data;
  logic [4:0]  len;
  logic [3:0]  rep;
  logic        out;
  logic        valid;
  logic        busy;
  logic        done;

  int n_vec;
  int n_err;

  logic expq[$];
  logic rxq[$];

  seq_pattern_tx #(
    .WIDTH (16),
    .CNT_W (5),
    .REP_W (4),
    .GAP   (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (data),
    .len   (len),
    .rep   (rep),
    .out   (out),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every valid bit must match the queue head.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("extra_bit", 32'(out), 32'hx);
      end else begin
        chk("out_bit", 32'(out), 32'(expq.pop_front()));
        rxq.push_back(out);
      end
    end else begin
      chk("idle_out", 32'(out), 32'd0);
    end
  end

  task automatic run_xfer(input logic [15:0] d,
                          input logic [4:0]  l,
                          input logic [3:0]  r,
                          input int          poke,
                          input string       tag);
    int lc, rc, cyc;
    bit got;
    lc = (l > 5'd16) ? 16 : int'(l);
    rc = (r == 4'd0) ? 1 : int'(r);
    for (int k = 0; k < rc; k++)
      for (int i = lc - 1; i >= 0; i--)
        expq.push_back(d[i]);
    data  = d;
    len   = l;
    rep   = r;
    start = 1'b1;
    cyc   = 0;
    got   = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        data  = ~d;
        len   = 5'd7;
        rep   = 4'd9;
      end
      if (poke > 0 && cyc == poke) start = 1'b1;
      if (poke > 0 && cyc == poke + 1) start = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (done === 1'b1) got = 1'b1;
    end
    chk({tag, "_cycles"}, 32'(cyc), 32'(rc * lc + 1));
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_q_empty"}, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int hits;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    start = 1'b0;
    data  = '0;
    len   = '0;
    rep   = '0;

    // Reset state, with start requested while held.
    #7;
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out",   32'(out),   32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // Basic 3-bit burst.
    run_xfer(16'h0005, 5'd3, 4'd1, 0, "c2");

    // Three back-to-back repeats, then a 101 detector.
    rxq.delete();
    run_xfer(16'h0005, 5'd3, 4'd3, 0, "c3");
    chk("c3_nbits", 32'(rxq.size()), 32'd9);
    hits = 0;
    for (int i = 2; i < rxq.size(); i++)
      if (rxq[i-2] && !rxq[i-1] && rxq[i])
        hits |= (1 << (i + 1));
    chk("c3_hits", 32'(hits), 32'h248);

    // len 0 gives only a done pulse; rep 0 acts as 1.
    run_xfer(16'h1234, 5'd0, 4'd2, 0, "c4a");
    run_xfer(16'h0002, 5'd2, 4'd0, 0, "c4b");

    // Full width, with a new request mid-burst.
    rxq.delete();
    run_xfer(16'hA5F0, 5'd16, 4'd1, 6, "c5");
    chk("c5_nbits", 32'(rxq.size()), 32'd16);

    // Length above WIDTH clamps.
    run_xfer(16'h8001, 5'd20, 4'd2, 0, "clamp");

    // Reset during the second bit aborts without done.
    expq.push_back(1'b1);
    expq.push_back(1'b0);
    expq.push_back(1'b1);
    data  = 16'h0005;
    len   = 5'd3;
    rep   = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("c6_out",   32'(out),   32'd0);
    chk("c6_valid", 32'(valid), 32'd0);
    chk("c6_busy",  32'(busy),  32'd0);
    chk("c6_done",  32'(done),  32'd0);
    expq.delete();
    repeat (3) begin
      @(negedge clk);
      chk("c6_nodone", 32'(done), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("c6_idle", 32'(busy), 32'd0);
    run_xfer(16'h0005, 5'd3, 4'd1, 0, "c6r");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
